// File: rtl/tristate_responder_if.sv
// tristate_responder_if
//   Groups the control and status signals of the tristate responder.
//   The shared data bus io is not part of this bundle. It stays a plain
//   module-level inout, so the tristate resolution happens on an ordinary
//   net that both ends drive.
//   Signals:
//     req  - initiator strobe; marks an address phase
//     wr   - sampled with req: 1 = write, 0 = read
//     o    - continuous mirror of io
//     oe   - responder is driving io
//     busy - responder is not idle
//     err  - sticky collision/protocol error flag
//   Modports: slave (responder side), master (initiator side).
interface tristate_responder_if #(
  parameter int W = 8
) ();
  logic         req;
  logic         wr;
  logic [W-1:0] o;
  logic         oe;
  logic         busy;
  logic         err;

  modport slave (
    input  req,
    input  wr,
    output o,
    output oe,
    output busy,
    output err
  );

  modport master (
    output req,
    output wr,
    input  o,
    input  oe,
    input  busy,
    input  err
  );
endinterface

// File: rtl/tristate_responder.sv
// tristate_responder
//   Target end of a half-duplex tristate bus. It samples an address and,
//   for writes, a data word from io into a DEPTH x W register file. For
//   reads it waits one turnaround cycle, then drives the stored word back
//   onto io for a single cycle and releases the bus again.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - tristate_responder_if.slave (req, wr in; o, oe, busy, err out)
//     io   - shared W-bit inout bus; driven only while oe=1, otherwise 'z
module tristate_responder #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  tristate_responder_if.slave      bus,
  inout  wire  [W-1:0]             io
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    TURN  = 2'd2,
    DRIVE = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [AW-1:0]  r_addr;
  logic [W-1:0]   r_drv;
  logic [W-1:0]   r_mem [DEPTH];
  logic           r_oe;
  logic           r_err;

  // The driver enable is a flop. Because its reset is asynchronous, the
  // bus is released the instant rst rises.
  assign io    = r_oe ? r_drv : {W{1'bz}};
  assign bus.o = io;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. A req outside IDLE never starts a transaction.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.req) w_next = bus.wr ? WDATA : TURN;
      WDATA:   w_next = IDLE;
      TURN:    w_next = DRIVE;
      DRIVE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.busy = (r_state != IDLE);
    bus.oe   = r_oe;
    bus.err  = r_err;
  end

  // Address latch, register file, read-data driver, enable and error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_drv  <= '0;
      r_oe   <= 1'b0;
      r_err  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      // oe is high for exactly the DRIVE cycle.
      r_oe <= (w_next == DRIVE);
      case (r_state)
        IDLE: begin
          // Address bits above AW are ignored, so addresses alias.
          if (bus.req) r_addr <= io[AW-1:0];
        end
        WDATA: begin
          // The data word is stored as sampled. A req in this cycle is legal.
          r_mem[r_addr] <= io;
        end
        TURN: begin
          r_drv <= r_mem[r_addr];
          // The initiator must not strobe while the bus is turning around.
          if (bus.req) r_err <= 1'b1;
        end
        DRIVE: begin
          if (bus.req) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tristate_responder.sv
module tb_tristate_responder;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         tb_en;
  logic [W-1:0] tb_val;
  wire  [W-1:0] io;

  always #5 clk = ~clk;

  assign io = tb_en ? tb_val : {W{1'bz}};

  tristate_responder_if #(.W(W)) bus ();

  tristate_responder #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .io  (io)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the register file contents and the sticky error flag.
  logic [W-1:0] mem_m [DEPTH];
  logic         err_m;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    err_m = 1'b0;
  endtask

  // Each transaction task starts just after a falling edge, with the DUT
  // idle. It returns just after the falling edge of the first idle cycle
  // that follows the transaction, so the next task can start back-to-back.
  task automatic do_write(input logic [W-1:0] a, input logic [W-1:0] d,
                          input bit hold_req);
    bus.req = 1'b1; bus.wr = 1'b1; tb_en = 1'b1; tb_val = a;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.oe !== 1'b0) begin
      errors++;
      $display("FAIL wr_wdata busy=%b oe=%b required busy=1 oe=0", bus.busy, bus.oe);
    end
    bus.req = hold_req; bus.wr = 1'($urandom_range(0, 1)); tb_val = d;
    @(negedge clk);
    mem_m[a % DEPTH] = d;
    checks++;
    if (bus.busy !== 1'b0 || bus.oe !== 1'b0 || bus.err !== err_m) begin
      errors++;
      $display("FAIL wr_done busy=%b oe=%b err=%b required busy=0 oe=0 err=%b",
               bus.busy, bus.oe, bus.err, err_m);
    end
    bus.req = 1'b0; tb_en = 1'b0;
  endtask

  task automatic do_read(input logic [W-1:0] a, input bit coll_turn, input bit coll_drive);
    logic [W-1:0] exp;
    logic [W-1:0] rel;
    exp = mem_m[a % DEPTH];
    bus.req = 1'b1; bus.wr = 1'b0; tb_en = 1'b1; tb_val = a;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.oe !== 1'b0) begin
      errors++;
      $display("FAIL rd_turn busy=%b oe=%b required busy=1 oe=0", bus.busy, bus.oe);
    end
    tb_en = 1'b0; bus.req = coll_turn; bus.wr = 1'($urandom_range(0, 1));
    @(negedge clk);
    if (coll_turn) err_m = 1'b1;
    checks++;
    if (bus.oe !== 1'b1 || io !== exp || bus.o !== exp || bus.busy !== 1'b1 ||
        bus.err !== err_m) begin
      errors++;
      $display("FAIL rd_drive addr=%h oe=%b io=%h o=%h busy=%b err=%b required oe=1 io=o=%h busy=1 err=%b",
               a, bus.oe, io, bus.o, bus.busy, bus.err, exp, err_m);
    end
    bus.req = coll_drive;
    @(negedge clk);
    if (coll_drive) err_m = 1'b1;
    checks++;
    if (bus.oe !== 1'b0 || bus.busy !== 1'b0 || bus.err !== err_m) begin
      errors++;
      $display("FAIL rd_release oe=%b busy=%b err=%b required oe=0 busy=0 err=%b",
               bus.oe, bus.busy, bus.err, err_m);
    end
    bus.req = 1'b0;
    // The bus has been released, so o follows whatever the initiator drives.
    rel = W'($urandom);
    tb_en = 1'b1; tb_val = rel;
    #1;
    checks++;
    if (bus.o !== rel) begin
      errors++;
      $display("FAIL rd_mirror o=%h required %h", bus.o, rel);
    end
    tb_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req = 1'b0; bus.wr = 1'b0; tb_en = 1'b0; tb_val = '0;
    #2;
    checks++;
    if (bus.oe !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset oe=%b busy=%b err=%b required 0 0 0", bus.oe, bus.busy, bus.err);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      do_read(W'(i) | W'({$urandom_range(0, 63), 2'b00}), 1'b0, 1'b0);
    end
  endtask

  task automatic test_write_read();
    do_write(8'h02, 8'hA5, 1'b0);
    @(negedge clk);
    do_read(8'h02, 1'b0, 1'b0);
  endtask

  task automatic test_alias();
    do_write(8'hF1, 8'h3C, 1'b0);
    do_read(8'h01, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_write(8'h01, 8'h11, 1'b1);
    do_write(8'h03, 8'h33, 1'b0);
    do_read(8'h01, 1'b0, 1'b0);
    do_read(8'h03, 1'b0, 1'b0);
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_err err=%b required 0", bus.err);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(W'($urandom), W'($urandom), bit'($urandom_range(0, 1)));
      else
        do_read(W'($urandom), 1'b0, 1'b0);
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_drive();
    logic [W-1:0] a;
    a = 8'h02;
    do_write(a, 8'h5A, 1'b0);
    bus.req = 1'b1; bus.wr = 1'b0; tb_en = 1'b1; tb_val = a;
    @(negedge clk);
    bus.req = 1'b0; tb_en = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.oe !== 1'b1 || io !== 8'h5A) begin
      errors++;
      $display("FAIL mid_drive_pre oe=%b io=%h required oe=1 io=5a", bus.oe, io);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.oe !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL mid_drive_rst oe=%b busy=%b err=%b required 0 0 0",
               bus.oe, bus.busy, bus.err);
    end
    @(negedge clk);
    rst = 1'b0;
    // Reset clears the whole register file.
    model_reset();
    do_read(a, 1'b0, 1'b0);
  endtask

  task automatic test_collision();
    do_write(8'h00, 8'h77, 1'b0);
    do_read(8'h00, 1'b1, 1'b0);
    do_write(8'h02, 8'h99, 1'b0);
    do_read(8'h02, 1'b0, 1'b0);
    do_read(8'h00, 1'b0, 1'b1);
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL coll_sticky err=%b required 1", bus.err);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL coll_clear err=%b required 0", bus.err);
    end
    do_read(8'h01, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alias();
    test_back_to_back();
    test_random();
    test_reset_mid_drive();
    test_collision();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
